// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the nemesys core.
// Owns the word-addressed PC. It registers the combinationally returned
// instruction into a one-entry fetch/decode register with a valid/ready
// handshake. The unconditional BR is resolved here with no bubbles, and a
// redirect from later stages flushes the held entry.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter int          WIDTH    = 32,
   parameter logic [4:0]  BR       = 5'b11111
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_en,
   output logic [31:0]      pc,
   input  logic [WIDTH-1:0] inst,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             if_valid,
   input  logic             if_ready,
   output logic [WIDTH-1:0] if_inst,
   output logic [31:0]      if_pc
);

   logic        advance;
   logic        is_br;
   logic [31:0] br_offset;
   logic [31:0] next_pc;

   // Decide whether to fetch this cycle and where the PC goes after it
   always_comb begin
      advance   = fetch_en & (~if_valid | if_ready) & ~redirect_valid;
      is_br     = (inst[31:27] == BR);
      br_offset = {{16{inst[15]}}, inst[15:0]};
      next_pc   = is_br ? (pc + br_offset) : (pc + 32'd1);
   end

   // PC and fetch/decode register: reset, then redirect, then advance, then drain or hold
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         if_valid <= 1'b0;
         if_inst  <= '0;
         if_pc    <= 32'd0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         if_valid <= 1'b0;
      end else if (advance) begin
         pc       <= next_pc;
         if_valid <= 1'b1;
         if_inst  <= inst;
         if_pc    <= pc;
      end else if (if_valid && if_ready) begin
         if_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage against hand-computed values.
// A small instruction memory returns words combinationally from the PC.
// A second instance with RESET_PC = 32'hFFFFFFFF covers PC wrap.
module tb_fetch_stage;

   localparam logic [31:0] MOV_R0_0 = 32'h0800_0000;
   localparam logic [31:0] MOV_R1_1 = 32'h0820_0001;
   localparam logic [31:0] ADD_R0   = 32'h1001_0000;
   localparam logic [31:0] BR_M1    = 32'hF800_FFFF;
   localparam logic [31:0] BR_0     = 32'hF800_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;

   logic [31:0] pc2;
   logic [31:0] inst2;
   logic        if_valid2;
   logic [31:0] if_inst2;
   logic [31:0] if_pc2;

   int total = 0;
   int bad   = 0;

   // Free-running clock
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      case (a)
         32'd0:   imem = MOV_R0_0;
         32'd1:   imem = MOV_R1_1;
         32'd2:   imem = ADD_R0;
         32'd3:   imem = BR_M1;
         32'd5:   imem = BR_0;
         default: imem = NOP;
      endcase
   endfunction

   // Combinational instruction memory for both instances
   always_comb begin
      inst  = imem(pc);
      inst2 = imem(pc2);
   end

   fetch_stage #(.RESET_PC(32'd0), .WIDTH(32), .BR(5'b11111)) dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc(pc), .inst(inst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .WIDTH(32), .BR(5'b11111)) dutWrap (
      .clk(clk), .rst(rst), .fetch_en(1'b1), .pc(pc2), .inst(inst2),
      .redirect_valid(1'b0), .redirect_pc(32'd0),
      .if_valid(if_valid2), .if_ready(1'b1), .if_inst(if_inst2), .if_pc(if_pc2)
   );

   task automatic applyStimulus(input logic en, input logic rdy,
                                input logic rv, input logic [31:0] rpc);
      fetch_en       = en;
      if_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkEntry(input string tag, input logic v,
                             input logic [31:0] ipc, input logic [31:0] ins,
                             input logic [31:0] npc);
      checkOutput({tag, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
      checkOutput({tag, ".if_pc"}, if_pc, ipc);
      checkOutput({tag, ".if_inst"}, if_inst, ins);
      checkOutput({tag, ".pc"}, pc, npc);
   endtask

   // Directed sequence of steps
   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("reset", 1'b0, 32'd0, 32'd0, 32'd0);
      checkOutput("reset.pc_wrapinst", pc2, 32'hFFFF_FFFF);

      rst = 1'b0;
      $display("[TB] run loop program");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("run0", 1'b1, 32'd0, MOV_R0_0, 32'd1);
      checkOutput("wrap.first_pc", if_pc2, 32'hFFFF_FFFF);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("run1", 1'b1, 32'd1, MOV_R1_1, 32'd2);
      checkOutput("wrap.next_pc", if_pc2, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("run2", 1'b1, 32'd2, ADD_R0, 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("run3_br", 1'b1, 32'd3, BR_M1, 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("run4", 1'b1, 32'd2, ADD_R0, 32'd3);

      $display("[TB] stall three cycles at if_pc=2");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
         checkEntry("stall", 1'b1, 32'd2, ADD_R0, 32'd3);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("resume0", 1'b1, 32'd3, BR_M1, 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("resume1", 1'b1, 32'd2, ADD_R0, 32'd3);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("resume2", 1'b1, 32'd3, BR_M1, 32'd2);

      $display("[TB] redirect while stalled");
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1);
      checkOutput("redir.if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("redir.pc", pc, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      checkEntry("redir.load", 1'b1, 32'd1, MOV_R1_1, 32'd2);

      $display("[TB] self-loop branch at 5");
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd5);
      checkOutput("loop.flush_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("loop.flush_pc", pc, 32'd5);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
         checkEntry("loop", 1'b1, 32'd5, BR_0, 32'd5);
      end

      $display("[TB] drain with fetch_en low");
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("drain.if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("drain.pc", pc, 32'd5);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("idle.if_valid", {31'd0, if_valid}, 32'd0);
      checkOutput("idle.pc", pc, 32'd5);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("reenable", 1'b1, 32'd5, BR_0, 32'd5);

      $display("[TB] reset together with redirect mid-stream");
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd3);
      checkEntry("rst_redir", 1'b0, 32'd0, 32'd0, 32'd0);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkEntry("after_rst", 1'b1, 32'd0, MOV_R0_0, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the nemesys core. It owns the program counter and drives it to `instr_mem`, which returns the addressed word combinationally in the same cycle. It registers that word, together with its PC, into a one-entry fetch/decode pipeline register with a valid/ready handshake toward decode. It resolves the unconditional `BR` in fetch with zero bubbles, and accepts a redirect/flush from later stages.

## Interface
Parameters:
- `RESET_PC`, 32'd0, PC value loaded on reset (word address).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_en`  in  1  run enable; while low no new fetch is issued, and the held output stays presented.
- `pc`  out  32  fetch address to `instr_mem` (word address); equals the internal PC register.
- `inst`  in  `WIDTH`  instruction word from `instr_mem` for the current `pc`, valid in the same cycle.
- `redirect_valid`  in  1  request from a later stage to flush and restart fetch.
- `redirect_pc`  in  32  restart address, sampled when `redirect_valid`=1.
- `if_valid`  out  1  fetch/decode register holds an instruction.
- `if_ready`  in  1  decode accepts the held instruction this cycle.
- `if_inst`  out  `WIDTH`  held instruction word.
- `if_pc`  out  32  PC of the held instruction.

## Operation
- Word-addressed PC. Sequential successor is `pc + 1`, modulo 2^32; 32'hFFFFFFFF wraps to 0.
- Opcode field is `inst[31:27]`. Branch immediate is `inst[15:0]`, sign-extended to 32 bits.
- `advance` = `fetch_en` & (!`if_valid` | `if_ready`) & !`redirect_valid`.
- Priority per cycle: `rst` > `redirect_valid` > `advance` > hold.
- `rst`=1:
  - PC <= `RESET_PC`.
  - `if_valid` <= 0, `if_inst` <= 0, `if_pc` <= 0.
- `redirect_valid`=1:
  - PC <= `redirect_pc`.
  - `if_valid` <= 0. The held instruction is discarded even if `if_ready`=1 this cycle; decode must not act on it.
  - `if_inst` and `if_pc` are don't-care.
- `advance`=1:
  - `if_inst` <= `inst`, `if_pc` <= PC, `if_valid` <= 1.
  - If `inst[31:27]` == `BR`, PC <= PC + sext(`inst[15:0]`). Otherwise PC <= PC + 1.
  - `BR` is still passed to decode, so later stages can count or trace it.
- Handshake, `if_valid`=1 & `if_ready`=1 with no advance (`fetch_en`=0): `if_valid` <= 0. The entry is consumed and no replacement is fetched.
- Hold, `if_valid`=1 & `if_ready`=0:
  - PC, `if_inst`, `if_pc` and `if_valid` are unchanged.
  - `if_inst` and `if_pc` must stay stable while `if_valid`=1 and not accepted.
- Branch arithmetic is 32-bit two's complement and wraps. Offset 16'h0000 is a self-loop; offset 16'hFFFF targets PC-1.
- No state machine beyond the PC and the valid bit. The two modes are "empty" (`if_valid`=0) and "full" (`if_valid`=1).

## Timing
- Reset values: `pc`=`RESET_PC`, `if_valid`=0, `if_inst`=0, `if_pc`=0.
- Latency: at the first rising edge with `rst`=0, `fetch_en`=1 and no redirect, `if_valid` becomes 1 and `if_pc`=`RESET_PC`. That is one cycle from PC to the decode register.
- Throughput is 1 instruction per cycle while `if_ready`=1, including across taken `BR`. There are no bubbles because the branch target is computed from the combinational `inst`.
- After redirect: `if_valid`=0 for exactly one cycle. The next edge loads the instruction at `redirect_pc`.
- `pc` changes only on clock edges and is never combinationally dependent on `inst`.
- Simultaneous cases:
  - `rst` with `redirect_valid`: reset wins.
  - Redirect while stalled (`if_ready`=0): redirect wins.
  - `if_ready`=1 with `fetch_en`=0: the entry drains and `if_valid` falls.

## Test plan
- Reset then run program {MOV R0,0; MOV R1,1; ADD R0,R1,R0; BR -1} at addresses 0..3, with `if_ready`=1 -> `if_pc` sequence 0,1,2,3,2,3,2,3,… on consecutive cycles with `if_valid`=1 throughout.
- Same program, drop `if_ready` for 3 cycles while `if_pc`=2 -> `if_pc`=2 and `if_inst` stay constant for those cycles, `pc` stays 3; resume gives 3,2,3 with no skipped or duplicated entry.
- `redirect_valid`=1, `redirect_pc`=1 while `if_pc`=3 and `if_ready`=0 -> next cycle `if_valid`=0; the following cycle `if_valid`=1 with `if_pc`=1 and `if_inst`=MOV R1,1.
- `BR` with offset 16'h0000 at address 5 -> `if_pc`=5 repeats every cycle. With `RESET_PC`=32'hFFFFFFFF and a non-branch instruction there, the next `if_pc` is 0 (wrap).
- Assert `rst` mid-stream while `if_valid`=1 and `redirect_valid`=1 -> next cycle `pc`=`RESET_PC`, `if_valid`=0, `if_inst`=0, `if_pc`=0.
- `fetch_en`=0 with `if_valid`=1 and `if_ready`=1 -> `if_valid` falls next cycle and `pc` is unchanged. Re-enabling resumes from that `pc`.
